// File: rtl/alu_mdu.sv
// alu_mdu: single-cycle ALU plus an iterative multiply/divide unit with HI/LO registers.
// Single-cycle ops finish in the cycle after the accept edge. MULT/DIV take one
// accept edge, WIDTH iteration edges and one sign-fix edge.
module alu_mdu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic             sign,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] out,
  output logic             ovf,
  output logic             dz,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned W2 = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [5:0] F_ADD  = 6'b000000;
  localparam logic [5:0] F_SUB  = 6'b000001;
  localparam logic [5:0] F_AND  = 6'b011000;
  localparam logic [5:0] F_OR   = 6'b011110;
  localparam logic [5:0] F_XOR  = 6'b010110;
  localparam logic [5:0] F_NOR  = 6'b010001;
  localparam logic [5:0] F_PASS = 6'b011010;
  localparam logic [5:0] F_SLL  = 6'b100000;
  localparam logic [5:0] F_SRL  = 6'b100001;
  localparam logic [5:0] F_SRA  = 6'b100011;
  localparam logic [5:0] F_EQ   = 6'b110011;
  localparam logic [5:0] F_NE   = 6'b110001;
  localparam logic [5:0] F_LT   = 6'b110101;
  localparam logic [5:0] F_LEZ  = 6'b111101;
  localparam logic [5:0] F_LTZ  = 6'b111011;
  localparam logic [5:0] F_GTZ  = 6'b111111;
  localparam logic [5:0] F_MFHI = 6'b001100;
  localparam logic [5:0] F_MFLO = 6'b001110;
  localparam logic [5:0] F_MULT = 6'b001000;
  localparam logic [5:0] F_DIV  = 6'b001010;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [W2-1:0]     acc_q, acc_d;      // MUL: {partial product, multiplier}; DIV: {remainder, quotient}
  logic [WIDTH-1:0]  opd_q, opd_d;      // MUL: multiplicand magnitude; DIV: divisor magnitude
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic              is_div_q, is_div_d;
  logic              dz_pend_q, dz_pend_d;
  logic [WIDTH-1:0]  a_raw_q, a_raw_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic              ovf_q, ovf_d;
  logic              dz_q, dz_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;

  logic [WIDTH:0]    add_full, sub_full;
  logic              lt;
  logic [WIDTH-1:0]  alu_res;
  logic              alu_ovf;

  logic              a_neg, b_neg;
  logic [WIDTH-1:0]  a_mag, b_mag;
  logic [WIDTH:0]    mul_sum;
  logic [WIDTH:0]    div_rsh;
  logic [WIDTH-1:0]  div_diff;
  logic              div_ge;
  logic [W2-1:0]     prod_fix;
  logic [WIDTH-1:0]  quo_fix, rem_fix;

  assign out  = out_q;
  assign ovf  = ovf_q;
  assign dz   = dz_q;
  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Single-cycle result and overflow for the current funct/operands
  always_comb begin
    alu_res  = '0;
    alu_ovf  = 1'b0;
    add_full = {1'b0, in1} + {1'b0, in2};
    sub_full = {1'b0, in1} - {1'b0, in2};
    lt       = sign ? ($signed(in1) < $signed(in2)) : (in1 < in2);
    case (funct)
      F_ADD: begin
        alu_res = add_full[WIDTH-1:0];
        alu_ovf = sign ? ((in1[WIDTH-1] == in2[WIDTH-1]) && (add_full[WIDTH-1] != in1[WIDTH-1]))
                       : add_full[WIDTH];
      end
      F_SUB: begin
        alu_res = sub_full[WIDTH-1:0];
        alu_ovf = sign ? ((in1[WIDTH-1] != in2[WIDTH-1]) && (sub_full[WIDTH-1] != in1[WIDTH-1]))
                       : sub_full[WIDTH];
      end
      F_AND:  alu_res = in1 & in2;
      F_OR:   alu_res = in1 | in2;
      F_XOR:  alu_res = in1 ^ in2;
      F_NOR:  alu_res = ~(in1 | in2);
      F_PASS: alu_res = in2;
      F_SLL:  alu_res = in2 << in1[SHW-1:0];
      F_SRL:  alu_res = in2 >> in1[SHW-1:0];
      F_SRA:  alu_res = WIDTH'($unsigned($signed(in2) >>> in1[SHW-1:0]));
      F_EQ:   alu_res = WIDTH'(in1 == in2);
      F_NE:   alu_res = WIDTH'(in1 != in2);
      F_LT:   alu_res = WIDTH'(lt);
      F_LEZ:  alu_res = WIDTH'(sign ? (in1[WIDTH-1] || (in1 == '0)) : (in1 == '0));
      F_LTZ:  alu_res = WIDTH'(sign & in1[WIDTH-1]);
      F_GTZ:  alu_res = WIDTH'(sign ? (!in1[WIDTH-1] && (in1 != '0)) : (in1 != '0));
      F_MFHI: alu_res = hi_q;
      F_MFLO: alu_res = lo_q;
      default: begin
        alu_res = '0;
        alu_ovf = 1'b0;
      end
    endcase
  end

  // Operand magnitudes, one iteration step of each unit, and final sign correction
  always_comb begin
    a_neg    = sign & in1[WIDTH-1];
    b_neg    = sign & in2[WIDTH-1];
    a_mag    = a_neg ? (~in1 + WIDTH'(1)) : in1;
    b_mag    = b_neg ? (~in2 + WIDTH'(1)) : in2;
    mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, opd_q};
    div_rsh  = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
    div_ge   = (div_rsh >= {1'b0, opd_q});
    div_diff = div_rsh[WIDTH-1:0] - opd_q;
    prod_fix = neg_res_q ? (~acc_q + W2'(1)) : acc_q;
    quo_fix  = neg_res_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? (~acc_q[W2-1:WIDTH] + WIDTH'(1)) : acc_q[W2-1:WIDTH];
  end

  // Next-state and output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opd_d     = opd_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    is_div_d  = is_div_q;
    dz_pend_d = dz_pend_q;
    a_raw_d   = a_raw_q;
    out_d     = out_q;
    ovf_d     = ovf_q;
    dz_d      = dz_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (funct == F_MULT) begin
            state_d   = S_MUL;
            busy_d    = 1'b1;
            cnt_d     = '0;
            acc_d     = {{WIDTH{1'b0}}, b_mag};
            opd_d     = a_mag;
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = 1'b0;
            is_div_d  = 1'b0;
            dz_pend_d = 1'b0;
          end else if (funct == F_DIV) begin
            state_d   = S_DIV;
            busy_d    = 1'b1;
            cnt_d     = '0;
            acc_d     = {{WIDTH{1'b0}}, a_mag};
            opd_d     = b_mag;
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            is_div_d  = 1'b1;
            dz_pend_d = (in2 == '0);
            a_raw_d   = in1;
          end else begin
            out_d  = alu_res;
            ovf_d  = alu_ovf;
            dz_d   = 1'b0;
            done_d = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[W2-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_FIX;
          cnt_d   = '0;
        end
      end
      S_DIV: begin
        acc_d = {(div_ge ? div_diff : div_rsh[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_FIX;
          cnt_d   = '0;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        ovf_d   = 1'b0;
        dz_d    = 1'b0;
        if (!is_div_q) begin
          hi_d = prod_fix[W2-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (dz_pend_q) begin
          hi_d = a_raw_q;
          lo_d = '1;
          dz_d = 1'b1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        out_d = lo_d;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register, asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opd_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_div_q  <= 1'b0;
      dz_pend_q <= 1'b0;
      a_raw_q   <= '0;
      out_q     <= '0;
      ovf_q     <= 1'b0;
      dz_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opd_q     <= opd_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      is_div_q  <= is_div_d;
      dz_pend_q <= dz_pend_d;
      a_raw_q   <= a_raw_d;
      out_q     <= out_d;
      ovf_q     <= ovf_d;
      dz_q      <= dz_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed vectors with a scoreboard queue; a monitor pops on every done pulse.
module tb_alu_mdu;

  logic        clk;
  logic        reset;
  logic        start;
  logic [5:0]  funct;
  logic        sign;
  logic [31:0] in1, in2;
  logic [31:0] out, hi, lo;
  logic        ovf, dz, busy, done;

  alu_mdu #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .funct(funct), .sign(sign),
    .in1(in1), .in2(in2), .out(out), .ovf(ovf), .dz(dz), .busy(busy),
    .done(done), .hi(hi), .lo(lo)
  );

  localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, AND_ = 6'b011000, OR_ = 6'b011110;
  localparam logic [5:0] XOR_ = 6'b010110, NOR_ = 6'b010001, PASS = 6'b011010;
  localparam logic [5:0] SLL = 6'b100000, SRL = 6'b100001, SRA = 6'b100011;
  localparam logic [5:0] EQ = 6'b110011, NE = 6'b110001, LT = 6'b110101;
  localparam logic [5:0] LEZ = 6'b111101, LTZ = 6'b111011, GTZ = 6'b111111;
  localparam logic [5:0] MFHI = 6'b001100, MFLO = 6'b001110, MULT = 6'b001000, DIV = 6'b001010;
  localparam logic [5:0] UNDEF = 6'b000111;

  // MULT/DIV: done is seen after the 34th edge counting the accept edge as edge 1,
  // i.e. 33 edges after the accept edge.
  localparam int MD_LAT = 33;

  typedef struct {
    int          id;
    logic [31:0] out;
    logic        ovf;
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;
  int          vid   = 0;
  logic [31:0] mdl_hi = '0;
  logic [31:0] mdl_lo = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && done === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pending op", cyc);
        end else begin
          e = sb.pop_front();
          chk($sformatf("v%0d.out", e.id), 64'(out), 64'(e.out));
          chk($sformatf("v%0d.ovf", e.id), 64'(ovf), 64'(e.ovf));
          chk($sformatf("v%0d.dz", e.id), 64'(dz), 64'(e.dz));
          chk($sformatf("v%0d.hi", e.id), 64'(hi), 64'(e.hi));
          chk($sformatf("v%0d.lo", e.id), 64'(lo), 64'(e.lo));
          chk($sformatf("v%0d.busy", e.id), 64'(busy), 64'd0);
          chk($sformatf("v%0d.lat", e.id), 64'(cyc - e.acc), 64'(e.lat));
        end
      end
    end
  end

  task automatic issue(input logic [5:0] f, input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eo, input logic eov, input logic edz, input int lat,
                       input bit push);
    exp_t e;
    int   w;
    w = 0;
    while (busy === 1'b1 && w < 200) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (busy !== 1'b0) begin
      n_cmp++;
      n_err++;
      $display("FAIL busy_timeout: got busy=%b expected 0 within 200 cycles", busy);
    end
    start = 1'b1; funct = f; sign = s; in1 = a; in2 = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) begin
      vid++;
      e.id = vid; e.out = eo; e.ovf = eov; e.dz = edz;
      e.hi = mdl_hi; e.lo = mdl_lo; e.lat = lat; e.acc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic op(input logic [5:0] f, input logic s, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] eo, input logic eov);
    issue(f, s, a, b, eo, eov, 1'b0, 0, 1'b1);
  endtask

  task automatic md(input logic [5:0] f, input logic s, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
    mdl_hi = ehi;
    mdl_lo = elo;
    issue(f, s, a, b, elo, 1'b0, edz, MD_LAT, 1'b1);
  endtask

  task automatic pulse_while_busy(input int n);
    for (int i = 0; i < n; i++) begin
      start = 1'b1; funct = ADD; sign = 1'b0; in1 = 32'd1; in2 = 32'd1;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("drain_pending", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected completion before 500000");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; funct = '0; sign = 1'b0; in1 = '0; in2 = '0;
    #23;
    chk("rst.out", 64'(out), 64'd0);
    chk("rst.ovf", 64'(ovf), 64'd0);
    chk("rst.dz", 64'(dz), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.hi", 64'(hi), 64'd0);
    chk("rst.lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Single-cycle ops, issued back-to-back
    op(ADD, 1'b1, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b1);
    op(UNDEF, 1'b0, 32'h1234_5678, 32'h1, 32'h0, 1'b0);
    op(ADD, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1);
    op(ADD, 1'b1, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0);
    op(SUB, 1'b0, 32'h3, 32'h5, 32'hFFFF_FFFE, 1'b1);
    op(SUB, 1'b1, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b1);
    op(SUB, 1'b1, 32'h3, 32'h5, 32'hFFFF_FFFE, 1'b0);
    op(AND_, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0);
    op(OR_, 1'b0, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0);
    op(XOR_, 1'b0, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0);
    op(NOR_, 1'b0, 32'h0F0F_0000, 32'h0000_0F0F, 32'hF0F0_F0F0, 1'b0);
    op(PASS, 1'b0, 32'h1111_1111, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
    op(SLL, 1'b0, 32'h4, 32'h1, 32'h10, 1'b0);
    op(SLL, 1'b0, 32'h24, 32'h1, 32'h10, 1'b0);
    op(SRL, 1'b0, 32'd31, 32'h8000_0000, 32'h1, 1'b0);
    op(SRA, 1'b0, 32'h4, 32'h8000_0000, 32'hF800_0000, 1'b0);
    op(EQ, 1'b0, 32'h5, 32'h5, 32'h1, 1'b0);
    op(NE, 1'b0, 32'h5, 32'h5, 32'h0, 1'b0);
    op(LT, 1'b1, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0);
    op(LT, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0);
    op(LEZ, 1'b1, 32'h8000_0000, 32'h0, 32'h1, 1'b0);
    op(LEZ, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 1'b0);
    op(LEZ, 1'b0, 32'h0, 32'h0, 32'h1, 1'b0);
    op(LTZ, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 1'b0);
    op(LTZ, 1'b1, 32'h8000_0000, 32'h0, 32'h1, 1'b0);
    op(GTZ, 1'b1, 32'h8000_0000, 32'h0, 32'h0, 1'b0);
    op(GTZ, 1'b0, 32'h8000_0000, 32'h0, 32'h1, 1'b0);
    op(GTZ, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
    op(MFHI, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);

    // Multiply: signed, with ignored start pulses while busy
    md(MULT, 1'b1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    chk("mult.busy", 64'(busy), 64'd1);
    pulse_while_busy(5);
    md(MULT, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    op(MFLO, 1'b0, 32'h0, 32'h0, 32'h0000_0001, 1'b0);

    // Divide cases
    md(DIV, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    op(MFHI, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0);
    op(MFLO, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFD, 1'b0);
    md(DIV, 1'b0, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF, 1'b1);
    op(ADD, 1'b0, 32'd1, 32'd1, 32'd2, 1'b0);
    md(DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
    md(DIV, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, 1'b0);
    md(DIV, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    md(DIV, 1'b1, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF, 1'b1);
    drain();

    // Reset in the middle of a MULT aborts it with no done pulse
    issue(MULT, 1'b0, 32'd5, 32'd5, 32'd0, 1'b0, 1'b0, 0, 1'b0);
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("abort.out", 64'(out), 64'd0);
    chk("abort.ovf", 64'(ovf), 64'd0);
    chk("abort.dz", 64'(dz), 64'd0);
    chk("abort.busy", 64'(busy), 64'd0);
    chk("abort.done", 64'(done), 64'd0);
    chk("abort.hi", 64'(hi), 64'd0);
    chk("abort.lo", 64'(lo), 64'd0);
    mdl_hi = '0;
    mdl_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    op(ADD, 1'b0, 32'd2, 32'd3, 32'd5, 1'b0);
    drain();

    // Outputs hold between done pulses
    repeat (3) @(negedge clk);
    chk("hold.out", 64'(out), 64'd5);
    chk("hold.done", 64'(done), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
